// File: rtl/fifo_push_arbiter_if.sv
// Requester and fifo-write-port bundle for the shared fifo push arbiter.
// The arbiter uses master; producers and the fifo side use slave.
interface fifo_push_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 5
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_full;
  logic                          fifo_push;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          busy;
  logic [CNT_WIDTH-1:0]          beat_cnt;

  modport master (
    input  req, req_last, req_data, fifo_full,
    output gnt, fifo_push, fifo_data_in,
    output busy, beat_cnt
  );

  modport slave (
    output req, req_last, req_data, fifo_full,
    input  gnt, fifo_push, fifo_data_in,
    input  busy, beat_cnt
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter sharing one fifo write port
// between NUM_REQ producers; a grant is held for a whole burst.
module fifo_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 5
) (
  input logic               clk,
  input logic               reset,
  fifo_push_arbiter_if.master bus
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t               r_state;
  state_t               w_state_n;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   w_gnt_n;
  logic [PW-1:0]        r_idx;
  logic [PW-1:0]        w_idx_n;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        w_ptr_n;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_n;
  logic [PW-1:0]        w_pick;
  logic                 w_any;
  logic                 w_req_g;
  logic                 w_last_g;
  logic                 w_xfer;
  logic                 w_release;
  logic [DATA_WIDTH-1:0] w_data;

  // descending scan so the nearest requester after r_ptr wins
  always_comb begin
    logic [PW-1:0] c;
    c      = '0;
    w_pick = '0;
    w_any  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = PW'((int'(r_ptr) + k) % NUM_REQ);
      if (bus.req[c]) begin
        w_pick = c;
        w_any  = 1'b1;
      end
    end
  end

  assign w_req_g  = bus.req[r_idx];
  assign w_last_g = bus.req_last[r_idx];
  assign w_xfer   = (r_state == S_GRANT) &
                    w_req_g & ~bus.fifo_full;

  // a full stall with req held is not a drop
  assign w_release = w_xfer
    ? (w_last_g |
       (r_cnt == CNT_WIDTH'(MAX_BURST - 1)))
    : ~w_req_g;

  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_idx_n   = r_idx;
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_n       = S_GRANT;
          w_gnt_n         = '0;
          w_gnt_n[w_pick] = 1'b1;
          w_idx_n         = w_pick;
          w_cnt_n         = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_state_n = S_IDLE;
          w_gnt_n   = '0;
          w_cnt_n   = '0;
          w_ptr_n   = r_idx;
        end else if (w_xfer) begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_ptr   <= PW'(NUM_REQ - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_idx   <= w_idx_n;
      r_ptr   <= w_ptr_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_state == S_GRANT && r_idx == PW'(i))
        w_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.fifo_push    = w_xfer & reset;
  assign bus.fifo_data_in = w_data;
  assign bus.gnt          = r_gnt;
  assign bus.busy         = (r_state == S_GRANT);
  assign bus.beat_cnt     = r_cnt;
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: burst-level reference model
// checked every cycle, plus directed literal expectations.
module tb_fifo_push_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int MB = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_push_arbiter_if #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
  ) bus ();

  fifo_push_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW),
    .MAX_BURST(MB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  function automatic bit bit_of(logic [N-1:0] v, int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [DW-1:0] slice(int i);
    return DW'(bus.req_data >> (i*DW));
  endfunction

  // producer state: beats left, burst length (0 = never last)
  int          rem [N];
  int          bl  [N];
  int          k   [N];
  logic [63:0] nxt [N];
  bit          acc [N];

  task automatic drive_all();
    logic [N-1:0]    r;
    logic [N-1:0]    l;
    logic [N*DW-1:0] d;
    r = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      if (rem[i] > 0) r |= N'(1) << i;
      if (rem[i] > 0 && bl[i] > 0 && k[i] == bl[i]-1)
        l |= N'(1) << i;
      d |= (N*DW)'(nxt[i]) << (i*DW);
    end
    bus.req      = r;
    bus.req_last = l;
    bus.req_data = d;
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        acc[i] = 1'b0;
        rem[i]--;
        nxt[i]++;
        k[i]++;
        if (bl[i] > 0 && k[i] == bl[i]) k[i] = 0;
      end
    end
    drive_all();
  end

  // reference model: current owner, beats taken, last owner
  int          owner = -1;
  int          beats = 0;
  int          lastp = N-1;
  int          glog[$];
  logic [63:0] dq[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner = -1;
      beats = 0;
      lastp = N-1;
    end else if (owner < 0) begin
      for (int s = 1; s <= N; s++) begin
        if (owner < 0 && bit_of(bus.req, (lastp+s) % N))
          owner = (lastp+s) % N;
      end
      if (owner >= 0) begin
        beats = 0;
        glog.push_back(owner);
      end
    end else if (bit_of(bus.req, owner) && !bus.fifo_full) begin
      beats++;
      if (bit_of(bus.req_last, owner) || beats == MB) begin
        lastp = owner;
        owner = -1;
      end
    end else if (!bit_of(bus.req, owner)) begin
      lastp = owner;
      owner = -1;
    end
  end

  logic [N-1:0]  e_gnt;
  logic          e_push;
  logic [DW-1:0] e_data;

  always @(negedge clk) begin
    e_gnt  = (owner >= 0) ? N'(1) << owner : '0;
    e_push = reset && owner >= 0 &&
             bit_of(bus.req, owner) && !bus.fifo_full;
    e_data = (owner >= 0) ? slice(owner) : '0;
    chk("gnt",  bus.gnt, e_gnt);
    chk("busy", bus.busy, owner >= 0);
    chk("cnt",  bus.beat_cnt, (owner >= 0) ? beats : 0);
    chk("push", bus.fifo_push, e_push);
    chk("data", bus.fifo_data_in, e_data);
    if (bus.fifo_push) dq.push_back(bus.fifo_data_in);
    for (int i = 0; i < N; i++)
      acc[i] = bit_of(bus.gnt, i) &&
               bit_of(bus.req, i) && !bus.fifo_full;
  end

  task automatic do_reset();
    reset = 1'b0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; bl[i] = 0; k[i] = 0;
      nxt[i] = '0; acc[i] = 1'b0;
    end
    drive_all();
    repeat (2) @(posedge clk);
    dq.delete();
    glog.delete();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  function automatic bit any_rem();
    for (int i = 0; i < N; i++)
      if (rem[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_done(string nm, int budget);
    int c = 0;
    while ((any_rem() || bus.gnt != '0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    #2;
    chk(nm, c < budget, 1'b1);
  endtask

  task automatic wait_q(string nm, int n, int budget);
    int c = 0;
    while (dq.size() < n && c < budget) begin
      @(posedge clk);
      #2;
      c++;
    end
    chk(nm, c < budget, 1'b1);
  endtask

  function automatic int gl(int i);
    return (glog.size() > i) ? glog[i] : -1;
  endfunction

  function automatic logic [63:0] dqa(int i);
    return (dq.size() > i) ? dq[i] : 64'hDEAD;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    do_reset();
    @(negedge clk); #1;
    chk("rst_gnt",  bus.gnt, 4'b0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_cnt",  bus.beat_cnt, 5'd0);
    chk("rst_push", bus.fifo_push, 1'b0);

    // single requester 2, three-beat burst
    @(posedge clk); #2;
    rem[2] = 3; bl[2] = 3; nxt[2] = 64'hA0;
    drive_all();
    @(negedge clk); #1;
    chk("t1_gnt_wait", bus.gnt, 4'b0000);
    @(negedge clk); #1;
    chk("t1_gnt",  bus.gnt, 4'b0100);
    chk("t1_d0",   bus.fifo_data_in, 64'hA0);
    chk("t1_p0",   bus.fifo_push, 1'b1);
    @(negedge clk); #1;
    chk("t1_d1",   bus.fifo_data_in, 64'hA1);
    chk("t1_c1",   bus.beat_cnt, 5'd1);
    @(negedge clk); #1;
    chk("t1_d2",   bus.fifo_data_in, 64'hA2);
    chk("t1_l2",   bus.req_last[2], 1'b1);
    @(negedge clk); #1;
    chk("t1_rel",  bus.gnt, 4'b0000);
    chk("t1_push", bus.fifo_push, 1'b0);
    chk("t1_ptr",  lastp, 2);
    chk("t1_n",    dq.size(), 3);

    // all four, two-beat bursts, two bursts each
    do_reset();
    for (int i = 0; i < N; i++) begin
      rem[i] = 4; bl[i] = 2; nxt[i] = 64'h100 * (i+1);
    end
    drive_all();
    wait_done("t2_done", 200);
    chk("t2_g0", gl(0), 0);
    chk("t2_g1", gl(1), 1);
    chk("t2_g2", gl(2), 2);
    chk("t2_g3", gl(3), 3);
    chk("t2_g4", gl(4), 0);
    chk("t2_n",  dq.size(), 16);
    for (int j = 0; j < 16; j++)
      chk("t2_q", dqa(j),
          64'h100 * ((j/2)%4 + 1) + (j/8)*2 + j%2);

    // forced release at MAX_BURST, then requester 2
    do_reset();
    rem[1] = 20; bl[1] = 0; nxt[1] = 64'h1000;
    rem[2] = 1;  bl[2] = 1; nxt[2] = 64'h2000;
    drive_all();
    wait_done("t3_done", 200);
    chk("t3_g0", gl(0), 1);
    chk("t3_g1", gl(1), 2);
    chk("t3_g2", gl(2), 1);
    chk("t3_n",  dq.size(), 21);
    chk("t3_q15", dqa(15), 64'h100F);
    chk("t3_q16", dqa(16), 64'h2000);
    chk("t3_q17", dqa(17), 64'h1010);

    // fifo full for 5 cycles after beat 3 of 6
    do_reset();
    rem[0] = 6; bl[0] = 6; nxt[0] = 64'h500;
    drive_all();
    wait_q("t4_wait", 3, 50);
    bus.fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk); #1;
      chk("t4_push", bus.fifo_push, 1'b0);
      chk("t4_cnt",  bus.beat_cnt, 5'd3);
      chk("t4_gnt",  bus.gnt, 4'b0001);
    end
    @(posedge clk); #2;
    bus.fifo_full = 1'b0;
    wait_done("t4_done", 100);
    chk("t4_n", dq.size(), 6);
    for (int j = 0; j < 6; j++)
      chk("t4_q", dqa(j), 64'h500 + j);

    // requester 3 drops after two beats
    do_reset();
    rem[3] = 2; bl[3] = 0; nxt[3] = 64'h800;
    drive_all();
    begin
      int c = 0;
      while (bus.gnt != 4'b1000 && c < 50) begin
        @(posedge clk); #2; c++;
      end
      chk("t5_wait", c < 50, 1'b1);
    end
    rem[1] = 2; bl[1] = 2; nxt[1] = 64'h900;
    drive_all();
    @(negedge clk); #1;
    chk("t5_p0", bus.fifo_data_in, 64'h800);
    @(negedge clk); #1;
    chk("t5_p1", bus.fifo_data_in, 64'h801);
    @(negedge clk); #1;
    chk("t5_hold", bus.gnt, 4'b1000);
    chk("t5_nop",  bus.fifo_push, 1'b0);
    @(negedge clk); #1;
    chk("t5_rel",  bus.gnt, 4'b0000);
    chk("t5_cnt",  bus.beat_cnt, 5'd0);
    wait_done("t5_done", 100);
    chk("t5_g0", gl(0), 3);
    chk("t5_g1", gl(1), 1);
    chk("t5_q2", dqa(2), 64'h900);
    chk("t5_n",  dq.size(), 4);

    // asynchronous reset mid-burst at beat 4
    do_reset();
    rem[2] = 8; bl[2] = 8; nxt[2] = 64'h600;
    drive_all();
    wait_q("t6_wait", 4, 50);
    rem[0] = 2; bl[0] = 2; nxt[0] = 64'h700;
    drive_all();
    #1 reset = 1'b0;
    #1;
    chk("t6_gnt",  bus.gnt, 4'b0000);
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_push", bus.fifo_push, 1'b0);
    chk("t6_cnt",  bus.beat_cnt, 5'd0);
    repeat (2) @(posedge clk);
    dq.delete();
    glog.delete();
    @(posedge clk);
    #2 reset = 1'b1;
    wait_done("t6_done", 100);
    chk("t6_g0", gl(0), 0);
    chk("t6_g1", gl(1), 2);
    chk("t6_q0", dqa(0), 64'h700);
    chk("t6_q2", dqa(2), 64'h604);
    chk("t6_n",  dq.size(), 6);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
